// File: rtl/apb_uart_regs.sv
// APB3 slave register block and FIFO sequencer for the APB-UART bridge.
// Decodes APB accesses into TX FIFO pushes and RX FIFO pops, holds CTRL/BAUD,
// collects status and sticky error flags and drives a registered level IRQ.
//
// Ports:
//   PCLK, PRESETn                 clock, async active-low reset
//   PSEL/PENABLE/PWRITE/PADDR/PWDATA, PRDATA/PREADY/PSLVERR   APB3 slave
//   TxWData, TxWEn, TxFull, TxEmpty                           TX FIFO write side
//   RxRInc, RxEmpty, RxRData, RxOverrun                        RX FIFO read side
//   TxEnable, RxEnable, BaudDiv                                UART configuration
//   Irq                                                        level interrupt
//
// The APB response is computed from the setup phase and registered, so it is
// valid in the first access cycle. DATA reads add one wait state (RD_WAIT).
module apb_uart_regs #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter logic [15:0] BAUD_RESET = 16'd27
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [3:0]            PADDR,
  input  logic [31:0]           PWDATA,
  output logic [31:0]           PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR,
  output logic [DATA_WIDTH-1:0] TxWData,
  output logic                  TxWEn,
  input  logic                  TxFull,
  input  logic                  TxEmpty,
  output logic                  RxRInc,
  input  logic                  RxEmpty,
  input  logic [DATA_WIDTH-1:0] RxRData,
  input  logic                  RxOverrun,
  output logic                  TxEnable,
  output logic                  RxEnable,
  output logic [15:0]           BaudDiv,
  output logic                  Irq
);

  localparam int unsigned CTRL_W = 5;
  localparam int unsigned BAUD_W = 16;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_BAUD   = 2'd3;

  typedef enum logic {IDLE, RD_WAIT} state_t;

  state_t                state_q, state_d;
  logic                  pready_q, pready_d;
  logic                  pslverr_q, pslverr_d;
  logic [31:0]           prdata_q, prdata_d;
  logic                  txwen_q, txwen_d;
  logic [DATA_WIDTH-1:0] txwdata_q, txwdata_d;
  logic                  rxrinc_q, rxrinc_d;
  logic [CTRL_W-1:0]     ctrl_q, ctrl_d;
  logic [BAUD_W-1:0]     baud_q, baud_d;
  logic                  rx_ovr_q, rx_ovr_d;
  logic                  tx_err_q, tx_err_d;
  logic                  rx_err_q, rx_err_d;
  logic                  irq_q, irq_d;

  logic       setup_c;
  logic       access_c;
  logic       wr_done_c;
  logic [1:0] reg_sel_c;
  logic [2:0] w1c_c;
  logic       tx_err_set_c;
  logic       rx_err_set_c;

  // Byte lanes above the widest register and the byte offset carry no information.
  logic unused_bits;
  assign unused_bits = ^{PADDR[1:0], PWDATA[31:16]};

  assign setup_c   = PSEL & ~PENABLE;
  assign access_c  = PSEL & PENABLE;
  assign reg_sel_c = PADDR[3:2];
  // Zero-wait writes complete in their first access cycle.
  assign wr_done_c = access_c & PWRITE & pready_q & (state_q == IDLE);

  // Next-state, response and register update logic.
  always_comb begin
    state_d      = state_q;
    pready_d     = 1'b1;
    pslverr_d    = 1'b0;
    prdata_d     = '0;
    txwen_d      = 1'b0;
    txwdata_d    = txwdata_q;
    rxrinc_d     = 1'b0;
    ctrl_d       = ctrl_q;
    baud_d       = baud_q;
    w1c_c        = 3'b000;
    tx_err_set_c = 1'b0;
    rx_err_set_c = 1'b0;

    // Setup phase: prepare the response presented in the first access cycle.
    if (setup_c) begin
      unique case (reg_sel_c)
        REG_DATA: begin
          if (PWRITE) begin
            if (TxFull) begin
              pslverr_d = 1'b1;
            end else begin
              txwen_d   = 1'b1;
              txwdata_d = PWDATA[DATA_WIDTH-1:0];
            end
          end else begin
            pready_d = 1'b0;
          end
        end
        REG_STATUS: if (!PWRITE) prdata_d = 32'({rx_err_q, tx_err_q, rx_ovr_q, RxEmpty, TxEmpty, TxFull});
        REG_CTRL:   if (!PWRITE) prdata_d = 32'(ctrl_q);
        REG_BAUD:   if (!PWRITE) prdata_d = 32'(baud_q);
        default: ;
      endcase
    end

    // DATA read sequencing.
    unique case (state_q)
      IDLE: begin
        if (access_c && !PWRITE && reg_sel_c == REG_DATA && !pready_q) begin
          state_d = RD_WAIT;
          if (RxEmpty) begin
            pslverr_d = 1'b1;
          end else begin
            rxrinc_d = 1'b1;
            prdata_d = 32'(RxRData);
          end
        end
      end
      RD_WAIT: begin
        state_d      = IDLE;
        rx_err_set_c = pslverr_q;
      end
      default: state_d = IDLE;
    endcase

    // Completing write cycle.
    if (wr_done_c) begin
      unique case (reg_sel_c)
        REG_DATA:   tx_err_set_c = pslverr_q;
        REG_STATUS: w1c_c = PWDATA[5:3];
        REG_CTRL:   ctrl_d = PWDATA[CTRL_W-1:0];
        REG_BAUD:   baud_d = PWDATA[BAUD_W-1:0];
        default: ;
      endcase
    end

    // Sticky flags: a set event in the same cycle as a clear wins.
    rx_ovr_d = RxOverrun    | (rx_ovr_q & ~w1c_c[0]);
    tx_err_d = tx_err_set_c | (tx_err_q & ~w1c_c[1]);
    rx_err_d = rx_err_set_c | (rx_err_q & ~w1c_c[2]);

    irq_d = (ctrl_q[2] & ~RxEmpty) | (ctrl_q[3] & TxEmpty) |
            (ctrl_q[4] & (rx_ovr_q | tx_err_q | rx_err_q));
  end

  // State and output registers.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q   <= IDLE;
      pready_q  <= 1'b1;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
      txwen_q   <= 1'b0;
      txwdata_q <= '0;
      rxrinc_q  <= 1'b0;
      ctrl_q    <= '0;
      baud_q    <= BAUD_RESET;
      rx_ovr_q  <= 1'b0;
      tx_err_q  <= 1'b0;
      rx_err_q  <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
      txwen_q   <= txwen_d;
      txwdata_q <= txwdata_d;
      rxrinc_q  <= rxrinc_d;
      ctrl_q    <= ctrl_d;
      baud_q    <= baud_d;
      rx_ovr_q  <= rx_ovr_d;
      tx_err_q  <= tx_err_d;
      rx_err_q  <= rx_err_d;
      irq_q     <= irq_d;
    end
  end

  assign PREADY   = pready_q;
  assign PSLVERR  = pslverr_q;
  assign PRDATA   = prdata_q;
  assign TxWEn    = txwen_q;
  assign TxWData  = txwdata_q;
  assign RxRInc   = rxrinc_q;
  assign TxEnable = ctrl_q[0];
  assign RxEnable = ctrl_q[1];
  assign BaudDiv  = baud_q;
  assign Irq      = irq_q;

endmodule
